// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO write side.
// Holds the arbiter FSM state type, the default pointer width and the Gray encoder.
package fifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int DEF_ADDRSIZE = 5;
  localparam int PTRW         = DEF_ADDRSIZE + 1;

  // Callers truncate the 32-bit result to their own pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return (b >> 1) ^ b;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches last+1, last+2, ... mod NREQ and returns the first requester found.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx
);

  logic          found_s;
  logic [IW-1:0] idx_s;

  // Rotating priority search starting just after the previous winner.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = IW'((int'(last) + k) % NREQ);
      if (!found_s && req[idx_s]) begin
        found_s      = 1'b1;
        win[idx_s]   = 1'b1;
        win_idx      = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side controller of the async FIFO: round-robin arbitration with per-packet
// lock among NREQ producers, write pointer (binary + Gray) and registered full flag.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DATASIZE = 32,
  parameter int ADDRSIZE = PTRW - 1
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_eop,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  output logic [NREQ-1:0]          gnt,
  input  logic [ADDRSIZE:0]        wq2_rptr,
  output logic [DATASIZE-1:0]      wdata,
  output logic [ADDRSIZE-1:0]      waddr,
  output logic                     wclken,
  output logic                     wfull,
  output logic [ADDRSIZE:0]        wptr
);

  localparam int IW = $clog2(NREQ);
  localparam int PW = ADDRSIZE + 1;

  state_t            state_r;
  logic [IW-1:0]     owner_r;
  logic [IW-1:0]     last_r;
  logic [PW-1:0]     wbin_r;
  logic [NREQ-1:0]   win_s;
  logic [IW-1:0]     win_idx_s;
  logic [NREQ-1:0]   gnt_s;
  logic [IW-1:0]     sel_idx_s;
  logic              wclken_s;
  logic [PW-1:0]     wbin_next_s;
  logic [PW-1:0]     wgray_next_s;
  logic [PW-1:0]     full_cmp_s;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req     (req),
    .last    (last_r),
    .win     (win_s),
    .win_idx (win_idx_s)
  );

  // Grant decode; full and reset both suppress any grant.
  always_comb begin
    gnt_s     = '0;
    sel_idx_s = owner_r;
    case (state_r)
      IDLE: begin
        if (!wrst && !wfull && (|req)) begin
          gnt_s     = win_s;
          sel_idx_s = win_idx_s;
        end else begin
          gnt_s = '0;
        end
      end
      LOCK: begin
        if (!wrst && !wfull && req[owner_r]) begin
          gnt_s[owner_r] = 1'b1;
        end else begin
          gnt_s = '0;
        end
      end
      default: gnt_s = '0;
    endcase
  end

  // Route the granted requester's beat to the memory write port.
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == sel_idx_s) begin
        wdata = req_data[i*DATASIZE +: DATASIZE];
      end else begin
        wdata = wdata;
      end
    end
  end

  assign wclken_s     = |gnt_s;
  assign gnt          = gnt_s;
  assign wclken       = wclken_s;
  assign waddr        = wbin_r[ADDRSIZE-1:0];
  assign wbin_next_s  = wbin_r + PW'(wclken_s);
  assign wgray_next_s = PW'(bin2gray(32'(wbin_next_s)));
  // Full: next write Gray equals read Gray with its two top bits inverted.
  assign full_cmp_s   = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

  // Arbitration FSM: lock follows a granted non-final beat until its eop is accepted.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_r <= IDLE;
      owner_r <= '0;
      last_r  <= IW'(NREQ - 1);
    end else begin
      case (state_r)
        IDLE: begin
          if (wclken_s) begin
            last_r  <= win_idx_s;
            owner_r <= win_idx_s;
            state_r <= req_eop[win_idx_s] ? IDLE : LOCK;
          end
        end
        LOCK: begin
          if (wclken_s && req_eop[owner_r]) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Write pointer pair and full flag, all registered from next-state values.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_r <= '0;
      wptr   <= '0;
      wfull  <= 1'b0;
    end else begin
      wbin_r <= wbin_next_s;
      wptr   <= wgray_next_s;
      wfull  <= (wgray_next_s == full_cmp_s);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter: a depth-32 instance (a) and a
// depth-4 instance (b) share producer inputs; each has its own read pointer.
module tb_fifo_wr_arbiter;

  logic         wclk;
  logic         wrst;
  logic [3:0]   req;
  logic [3:0]   req_eop;
  logic [127:0] req_data;
  logic [5:0]   rptr_a;
  logic [2:0]   rptr_b;
  logic [3:0]   gnt_a, gnt_b;
  logic [31:0]  wdata_a, wdata_b;
  logic [4:0]   waddr_a;
  logic [1:0]   waddr_b;
  logic         wclken_a, wclken_b;
  logic         wfull_a, wfull_b;
  logic [5:0]   wptr_a;
  logic [2:0]   wptr_b;

  int tests;
  int fails;

  fifo_wr_arbiter #(.NREQ(4), .DATASIZE(32), .ADDRSIZE(5)) dut_a (
    .wclk(wclk), .wrst(wrst), .req(req), .req_eop(req_eop), .req_data(req_data),
    .gnt(gnt_a), .wq2_rptr(rptr_a), .wdata(wdata_a), .waddr(waddr_a),
    .wclken(wclken_a), .wfull(wfull_a), .wptr(wptr_a)
  );

  fifo_wr_arbiter #(.NREQ(4), .DATASIZE(32), .ADDRSIZE(2)) dut_b (
    .wclk(wclk), .wrst(wrst), .req(req), .req_eop(req_eop), .req_data(req_data),
    .gnt(gnt_b), .wq2_rptr(rptr_b), .wdata(wdata_b), .waddr(waddr_b),
    .wclken(wclken_b), .wfull(wfull_b), .wptr(wptr_b)
  );

  always #5 wclk = ~wclk;

  task automatic next_edge();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    req = 4'b0000;
    req_eop = 4'b0000;
    next_edge();
    wrst = 1'b0;
  endtask

  task automatic test_reset();
    wrst = 1'b1;
    req = 4'b1111;
    req_eop = 4'b1111;
    @(negedge wclk);
    tests++; if (gnt_a !== 4'b0000) begin fails++; $display("FAIL reset_gnt_in_rst got %b want 0000", gnt_a); end
    tests++; if (wclken_a !== 1'b0) begin fails++; $display("FAIL reset_wclken_in_rst got %b want 0", wclken_a); end
    next_edge();
    wrst = 1'b0;
    req = 4'b0000;
    @(negedge wclk);
    tests++; if (gnt_a !== 4'b0000) begin fails++; $display("FAIL reset_gnt got %b want 0000", gnt_a); end
    tests++; if (wclken_a !== 1'b0) begin fails++; $display("FAIL reset_wclken got %b want 0", wclken_a); end
    tests++; if (wptr_a !== 6'd0) begin fails++; $display("FAIL reset_wptr got %h want 00", wptr_a); end
    tests++; if (wfull_a !== 1'b0) begin fails++; $display("FAIL reset_wfull got %b want 0", wfull_a); end
    tests++; if (wptr_b !== 3'd0 || wfull_b !== 1'b0) begin fails++; $display("FAIL reset_b got wptr=%b wfull=%b want 000/0", wptr_b, wfull_b); end
    next_edge();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt [5];
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
    exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
    req = 4'b1111;
    req_eop = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge wclk);
      tests++; if (gnt_a !== exp_gnt[k]) begin fails++; $display("FAIL rr_gnt[%0d] got %b want %b", k, gnt_a, exp_gnt[k]); end
      tests++; if (waddr_a !== 5'(k)) begin fails++; $display("FAIL rr_waddr[%0d] got %0d want %0d", k, waddr_a, k); end
      tests++; if (wdata_a !== 32'(32'hD0 + (k % 4))) begin fails++; $display("FAIL rr_wdata[%0d] got %h want %h", k, wdata_a, 32'hD0 + (k % 4)); end
      next_edge();
    end
    req = 4'b0000;
  endtask

  task automatic test_lock();
    logic [3:0] v_req [5];
    logic [3:0] v_eop [5];
    logic [3:0] v_gnt [5];
    v_req[0] = 4'b0011; v_eop[0] = 4'b0010; v_gnt[0] = 4'b0001;
    v_req[1] = 4'b0010; v_eop[1] = 4'b0010; v_gnt[1] = 4'b0000;
    v_req[2] = 4'b0011; v_eop[2] = 4'b0010; v_gnt[2] = 4'b0001;
    v_req[3] = 4'b0011; v_eop[3] = 4'b0011; v_gnt[3] = 4'b0001;
    v_req[4] = 4'b0011; v_eop[4] = 4'b0011; v_gnt[4] = 4'b0010;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req = v_req[k];
      req_eop = v_eop[k];
      @(negedge wclk);
      tests++; if (gnt_a !== v_gnt[k]) begin fails++; $display("FAIL lock_gnt[%0d] got %b want %b", k, gnt_a, v_gnt[k]); end
      next_edge();
    end
    req = 4'b0000;
  endtask

  task automatic test_full();
    do_reset();
    rptr_b = 3'b000;
    req = 4'b0001;
    req_eop = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge wclk);
      tests++; if (gnt_b !== 4'b0001 || wfull_b !== 1'b0) begin fails++; $display("FAIL full_fill[%0d] got gnt=%b wfull=%b want 0001/0", k, gnt_b, wfull_b); end
      next_edge();
    end
    req = 4'b0011;
    @(negedge wclk);
    tests++; if (wfull_b !== 1'b1) begin fails++; $display("FAIL full_flag got %b want 1", wfull_b); end
    tests++; if (wptr_b !== 3'b110) begin fails++; $display("FAIL full_wptr got %b want 110", wptr_b); end
    tests++; if (gnt_b !== 4'b0000 || wclken_b !== 1'b0) begin fails++; $display("FAIL full_blocked got gnt=%b wclken=%b want 0000/0", gnt_b, wclken_b); end
    next_edge();
    @(negedge wclk);
    tests++; if (wptr_b !== 3'b110 || wfull_b !== 1'b1) begin fails++; $display("FAIL full_hold got wptr=%b wfull=%b want 110/1", wptr_b, wfull_b); end
    next_edge();
    rptr_b = 3'b001;
    @(negedge wclk);
    tests++; if (wfull_b !== 1'b1) begin fails++; $display("FAIL full_before_release got %b want 1", wfull_b); end
    next_edge();
    @(negedge wclk);
    tests++; if (wfull_b !== 1'b0) begin fails++; $display("FAIL full_release got %b want 0", wfull_b); end
    tests++; if (gnt_b !== 4'b0001) begin fails++; $display("FAIL full_resume_lock got %b want 0001", gnt_b); end
    tests++; if (waddr_b !== 2'd0) begin fails++; $display("FAIL full_resume_waddr got %0d want 0", waddr_b); end
    next_edge();
    @(negedge wclk);
    tests++; if (wfull_b !== 1'b1 || wptr_b !== 3'b111) begin fails++; $display("FAIL full_again got wfull=%b wptr=%b want 1/111", wfull_b, wptr_b); end
    req = 4'b0000;
    next_edge();
  endtask

  task automatic test_wrap();
    logic [5:0] cnt;
    do_reset();
    cnt = 6'd0;
    rptr_a = 6'd0;
    req = 4'b0100;
    req_eop = 4'b1111;
    for (int k = 0; k < 34; k++) begin
      rptr_a = cnt ^ (cnt >> 1);
      @(negedge wclk);
      tests++; if (waddr_a !== 5'(k % 32)) begin fails++; $display("FAIL wrap_waddr[%0d] got %0d want %0d", k, waddr_a, k % 32); end
      tests++; if (wptr_a !== (cnt ^ (cnt >> 1))) begin fails++; $display("FAIL wrap_wptr[%0d] got %b want %b", k, wptr_a, cnt ^ (cnt >> 1)); end
      tests++; if (gnt_a !== 4'b0100 || wfull_a !== 1'b0) begin fails++; $display("FAIL wrap_flow[%0d] got gnt=%b wfull=%b want 0100/0", k, gnt_a, wfull_a); end
      next_edge();
      cnt = cnt + 6'd1;
    end
    req = 4'b0000;
    @(negedge wclk);
    tests++; if (wptr_a !== 6'b110011) begin fails++; $display("FAIL wrap_final_wptr got %b want 110011", wptr_a); end
    next_edge();
    rptr_a = 6'd0;
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    req = 4'b0011;
    req_eop = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      @(negedge wclk);
      tests++; if (gnt_a !== 4'b0001) begin fails++; $display("FAIL midlock_beat[%0d] got %b want 0001", k, gnt_a); end
      next_edge();
    end
    #2;
    wrst = 1'b1;
    #1;
    tests++; if (gnt_a !== 4'b0000 || wclken_a !== 1'b0) begin fails++; $display("FAIL midlock_rst_gnt got gnt=%b wclken=%b want 0000/0", gnt_a, wclken_a); end
    tests++; if (wptr_a !== 6'd0 || waddr_a !== 5'd0) begin fails++; $display("FAIL midlock_rst_ptr got wptr=%b waddr=%0d want 0/0", wptr_a, waddr_a); end
    next_edge();
    wrst = 1'b0;
    req_eop = 4'b0011;
    @(negedge wclk);
    tests++; if (gnt_a !== 4'b0001 || waddr_a !== 5'd0) begin fails++; $display("FAIL midlock_first got gnt=%b waddr=%0d want 0001/0", gnt_a, waddr_a); end
    next_edge();
    @(negedge wclk);
    tests++; if (gnt_a !== 4'b0010) begin fails++; $display("FAIL midlock_unlocked got %b want 0010", gnt_a); end
    next_edge();
    req = 4'b0000;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    wclk = 1'b0;
    wrst = 1'b1;
    req = 4'b0000;
    req_eop = 4'b0000;
    req_data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    rptr_a = 6'd0;
    rptr_b = 3'd0;
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_wrap();
    test_reset_mid_lock();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
